ds_decimator: RTL
=================

DS_DECIMATOR -- requirements
Module: ds_decimator

Interface
REQ-001 Parameter DECIM, default 16, decimation ratio; legal values are 8, 16, 32 and 64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 ds_in  input  4  modulator code; bit3 is sign (0 = positive, 1 = negative), bits 2:0 are magnitude.
REQ-005 ds_valid  input  1  ds_in is accepted on a rising edge where ds_valid=1.
REQ-006 pcm_out  output  14  signed decimated PCM word.
REQ-007 pcm_valid  output  1  one-cycle strobe; pcm_out holds a new word.
REQ-008 settled  output  1  high once the filter history is full.

Function
REQ-009 Code map: level s = +(2*mag+1) if bit3=0, else -(2*mag+1); 5-bit signed, range -15..+15, never zero.
REQ-010 Filter: 3rd-order CIC (sinc3); L=log2(DECIM); internal width W=5+3*L.
REQ-011 Integrators: on each accepted sample, i1<=i1+s, i2<=i2+i1, i3<=i3+i2 (registered chain); held when ds_valid=0.
REQ-012 Integrators and combs: two's-complement wrap-around on overflow, with no saturation.
REQ-013 Decimation counter: 0..DECIM-1, advances only on accepted samples; on the accepted sample with count=DECIM-1 it wraps to 0 and sets a one-cycle internal strobe.
REQ-014 Combs: on the strobe cycle, c1=i3-d1, c2=c1-d2, c3=c2-d3; then d1<=i3, d2<=c1, d3<=c2.
REQ-015 Output: pcm_out <= c3 >>> (W-14), i.e. bits W-1..W-14; for DECIM=8 no shift.
REQ-016 Latency: completing sample accepted at edge E; pcm_out/pcm_valid update at edge E+1; pcm_valid returns low at edge E+2.
REQ-017 pcm_out holds its value between strobes.
REQ-018 No back-pressure: pcm_valid is never stalled, and a word not captured is lost.
REQ-019 Gaps in ds_valid stretch the decimation period but do not change results.
REQ-020 settled rises with the 3rd pcm_valid after reset and stays high until reset.

Reset
REQ-021 Asynchronous reset clears integrators, comb delays, counter, strobe and settle count.
REQ-022 Reset values: pcm_out=0, pcm_valid=0, settled=0.
REQ-023 Reset mid-block discards the partial block.
REQ-024 The first accepted sample after reset release is count 0.

Configuration
REQ-025 Macro DS_DEC_SETTLE_MASK_EN.
- Defined: pcm_valid is suppressed for the first 2 output words after reset, so the first pcm_valid coincides with settled rising. pcm_out still updates.
- Undefined: pcm_valid pulses for every word from the first.
- settled behaves identically in both cases.

Structure
REQ-026 Package ds_pkg holds the following:
- constants DS_CODE_W=4 and PCM_W=14;
- the signed level typedef (5-bit);
- the code-to-level function.
REQ-027 Sub-module ds_code_map (combinational ds_in -> s) is instantiated once.
REQ-028 Integrator, counter and comb logic stay in ds_decimator.

Verification (DECIM=16, W=17, shift 3)
REQ-029 Constant ds_in=4'b0111 (s=+15), ds_valid=1 -> from the 3rd word on, pcm_out=7680 every 16 cycles.
REQ-030 Constant ds_in=4'b1000 (s=-1) -> steady pcm_out=-512; alternating 4'b0000/4'b1000 -> steady pcm_out=0.
REQ-031 Latency check: 16th accepted sample at edge E -> pcm_valid high exactly between edges E+1 and E+2, and no other pulse within that block.
REQ-032 ds_valid toggled 1-0-1-0 with constant 4'b0111 -> one word per 16 accepted samples (32 cycles), steady value 7680.
REQ-033 Reset asserted after 9 samples, then released -> outputs 0 immediately; next pcm_valid after 16 new samples.
- With DS_DEC_SETTLE_MASK_EN: first pcm_valid at the 3rd word, together with settled.
- Without the macro: first pcm_valid at the 1st word.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared constants, level type and code-to-level mapping for the delta-sigma decimator.
package ds_pkg;

  localparam int DS_CODE_W = 4;
  localparam int PCM_W     = 14;

  typedef logic signed [4:0] ds_level_t;

  // Sign/magnitude code to odd level +-(2*mag+1); zero is not representable.
  function automatic ds_level_t ds_code_to_level(input logic [DS_CODE_W-1:0] code);
    ds_level_t odd;
    odd = {1'b0, code[2:0], 1'b1};
    return code[3] ? -odd : odd;
  endfunction

endpackage

// File: rtl/ds_code_map.sv
// Combinational map from the 4-bit modulator code to its signed 5-bit level.
module ds_code_map
  import ds_pkg::*;
(
  input  logic [DS_CODE_W-1:0] code_i,
  output ds_level_t            level_o
);

  assign level_o = ds_code_to_level(code_i);

endmodule

// File: rtl/ds_decimator.sv
// ds_decimator: sinc3 CIC decimator for a sign/magnitude delta-sigma stream.
// Build option DS_DEC_SETTLE_MASK_EN suppresses pcm_valid for the first two words after reset.
module ds_decimator
  import ds_pkg::*;
#(
  parameter int DECIM = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DS_CODE_W-1:0]    ds_in,
  input  logic                    ds_valid,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic                    pcm_valid,
  output logic                    settled
);

  localparam int L  = $clog2(DECIM);
  localparam int W  = 5 + 3 * L;
  localparam int SH = W - PCM_W;
  localparam logic [L-1:0] CNT_LAST = L'(DECIM - 1);

  ds_level_t               level;
  logic signed [W-1:0]     s_ext;
  logic signed [W-1:0]     i1_q, i2_q, i3_q;
  logic signed [W-1:0]     d1_q, d2_q, d3_q;
  logic signed [W-1:0]     c1, c2;
  logic [L-1:0]            cnt_q;
  logic                    strobe_q;
  logic [1:0]              words_q;
  logic signed [PCM_W-1:0] pcm_d, pcm_q;
  logic                    pcm_valid_q, settled_q;
  logic                    word_en;

  ds_code_map u_code_map (
    .code_i (ds_in),
    .level_o(level)
  );

  assign s_ext = {{(W-5){level[4]}}, level};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
    end else if (ds_valid) begin
      i1_q <= i1_q + s_ext;
      i2_q <= i2_q + i1_q;
      i3_q <= i3_q + i2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= ds_valid && (cnt_q == CNT_LAST);
      if (ds_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign c1 = i3_q - d1_q;
  assign c2 = c1 - d2_q;

  // Only the kept top bits of c3 are formed; the borrow folds in the dropped low bits.
  generate
    if (SH == 0) begin : g_noshift
      assign pcm_d = c2 - d3_q;
    end else begin : g_shift
      logic borrow;
      assign borrow = c2[SH-1:0] < d3_q[SH-1:0];
      assign pcm_d  = c2[W-1:SH] - d3_q[W-1:SH] - PCM_W'(borrow);
    end
  endgenerate

`ifdef DS_DEC_SETTLE_MASK_EN
  assign word_en = words_q[1];
`else
  assign word_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      words_q     <= '0;
      settled_q   <= 1'b0;
    end else begin
      pcm_valid_q <= strobe_q && word_en;
      if (strobe_q) begin
        d1_q  <= i3_q;
        d2_q  <= c1;
        d3_q  <= c2;
        pcm_q <= pcm_d;
        if (words_q != 2'd3) begin
          words_q <= words_q + 2'd1;
        end
        if (words_q == 2'd2) begin
          settled_q <= 1'b1;
        end
      end
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign settled   = settled_q;

endmodule
